// File: rtl/hazard_stall_unit.sv
// Load-use stall, memory freeze and branch squash control for the pipeline
// registers upstream of EX, with saturating stall/freeze statistics.
module hazard_stall_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       PR_ID_Rs,
    input  logic [4:0]       PR_ID_Rt,
    input  logic             PR_ID_UsesRt,
    input  logic             ID_Valid,
    input  logic             ID_MemRead,
    input  logic             ID_RegWrite,
    input  logic [4:0]       ID_Rd,
    input  logic             EX_MR_MemAccess,
    input  logic             MR_mem_ready,
    input  logic             branch_flush,
    output logic             PC_Write,
    output logic             PR_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MR_Write,
    output logic             MR_WB_Write,
    output logic             PR_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] freeze_count,
    output logic             mem_timeout
);

    typedef enum logic {RUN, WAIT} state_t;

    localparam logic [CNT_W-1:0] TO_L = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic             ex_ld_v_q, ex_ld_v_d;
    logic [4:0]       ex_ld_rd_q, ex_ld_rd_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic             timeout_q, timeout_d;
    logic             freeze;
    logic             lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    assign freeze = EX_MR_MemAccess & ~MR_mem_ready;

    // A load in EX whose nonzero destination is read by the ID instruction
    assign lu = ID_Valid & ex_ld_v_q & (ex_ld_rd_q != 5'd0) &
                ((PR_ID_Rs == ex_ld_rd_q) |
                 (PR_ID_UsesRt & (PR_ID_Rt == ex_ld_rd_q)));

    // Prioritised pipeline-register control: rst, freeze, branch, load-use
    always_comb begin
        PC_Write     = 1'b1;
        PR_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MR_Write  = 1'b1;
        MR_WB_Write  = 1'b1;
        PR_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        if (rst) begin
            PC_Write     = 1'b0;
            PR_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MR_Write  = 1'b0;
            MR_WB_Write  = 1'b0;
            PR_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (freeze) begin
            PC_Write    = 1'b0;
            PR_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            EX_MR_Write = 1'b0;
            MR_WB_Write = 1'b0;
        end else if (branch_flush) begin
            PR_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (lu) begin
            PC_Write     = 1'b0;
            PR_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    // Next-state: FSM, wait counter, timeout flag, shadow and statistics
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        ex_ld_v_d    = ex_ld_v_q;
        ex_ld_rd_d   = ex_ld_rd_q;
        stall_cnt_d  = stall_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        unique case (state_q)
            RUN:  if (freeze)  state_d = WAIT;
            WAIT: if (!freeze) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (state_d == WAIT) begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end else begin
            wait_cnt_d = '0;
        end
        if (freeze && (sat_inc(wait_cnt_q) >= TO_L)) begin
            timeout_d = 1'b1;
        end
        if (ID_EX_Write) begin
            ex_ld_v_d  = ID_Valid & ID_MemRead & ID_RegWrite & ~ID_EX_Bubble;
            ex_ld_rd_d = ID_Rd;
        end
        if (!freeze && !branch_flush && lu) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (freeze) begin
            freeze_cnt_d = sat_inc(freeze_cnt_q);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            ex_ld_v_q    <= 1'b0;
            ex_ld_rd_q   <= 5'd0;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            ex_ld_v_q    <= ex_ld_v_d;
            ex_ld_rd_q   <= ex_ld_rd_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_count  = stall_cnt_q;
    assign freeze_count = freeze_cnt_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed vector bench for hazard_stall_unit, small counters and timeout
// so that saturation and the timeout flag are reachable.
module tb_hazard_stall_unit;

    localparam int CW = 4;

    localparam logic [6:0] NORM = 7'b11111_00;
    localparam logic [6:0] LU   = 7'b00111_01;
    localparam logic [6:0] FRZ  = 7'b00000_00;
    localparam logic [6:0] BR   = 7'b11111_11;
    localparam logic [6:0] RST  = 7'b00000_11;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       v;
        logic       mr;
        logic       rw;
        logic [4:0] rd;
        logic       ma;
        logic       rdy;
        logic       bf;
        logic [6:0] en;
        int         sc;
        int         fc;
        logic       to;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    PR_ID_Rs, PR_ID_Rt, ID_Rd;
    logic          PR_ID_UsesRt, ID_Valid, ID_MemRead, ID_RegWrite;
    logic          EX_MR_MemAccess, MR_mem_ready, branch_flush;
    logic          PC_Write, PR_ID_Write, ID_EX_Write, EX_MR_Write;
    logic          MR_WB_Write, PR_ID_Flush, ID_EX_Bubble;
    logic [CW-1:0] stall_count, freeze_count;
    logic          mem_timeout;
    logic [6:0]    en;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vt[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(CW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .PR_ID_Rs(PR_ID_Rs), .PR_ID_Rt(PR_ID_Rt),
        .PR_ID_UsesRt(PR_ID_UsesRt), .ID_Valid(ID_Valid),
        .ID_MemRead(ID_MemRead), .ID_RegWrite(ID_RegWrite),
        .ID_Rd(ID_Rd), .EX_MR_MemAccess(EX_MR_MemAccess),
        .MR_mem_ready(MR_mem_ready), .branch_flush(branch_flush),
        .PC_Write(PC_Write), .PR_ID_Write(PR_ID_Write),
        .ID_EX_Write(ID_EX_Write), .EX_MR_Write(EX_MR_Write),
        .MR_WB_Write(MR_WB_Write), .PR_ID_Flush(PR_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .stall_count(stall_count),
        .freeze_count(freeze_count), .mem_timeout(mem_timeout)
    );

    assign en = {PC_Write, PR_ID_Write, ID_EX_Write, EX_MR_Write,
                 MR_WB_Write, PR_ID_Flush, ID_EX_Bubble};

    function automatic vec_t mk(input int r, rs, rt, ut, v, mr, rw, rd,
                                input int ma, rdy, bf,
                                input logic [6:0] e, input int sc, fc, to);
        vec_t x;
        x.rst = 1'(r);   x.rs = 5'(rs);  x.rt = 5'(rt);  x.ut = 1'(ut);
        x.v = 1'(v);     x.mr = 1'(mr);  x.rw = 1'(rw);  x.rd = 5'(rd);
        x.ma = 1'(ma);   x.rdy = 1'(rdy); x.bf = 1'(bf);
        x.en = e;        x.sc = sc;      x.fc = fc;      x.to = 1'(to);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst;          PR_ID_Rs = x.rs;      PR_ID_Rt = x.rt;
        PR_ID_UsesRt = x.ut;  ID_Valid = x.v;       ID_MemRead = x.mr;
        ID_RegWrite = x.rw;   ID_Rd = x.rd;         EX_MR_MemAccess = x.ma;
        MR_mem_ready = x.rdy; branch_flush = x.bf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(mk(1, 0,0,0, 0,0,0,0, 0,0,0, RST,0,0,0));
        step();
        step();

        vt.push_back(mk(0,  0, 0,0, 0,0,0,0, 0,0,0, NORM,0,0,0));
        vt.push_back(mk(0, 29, 8,0, 1,1,1,8, 0,0,0, NORM,0,0,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,0, LU,  0,0,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0, 29, 0,0, 1,1,1,0, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0,  0, 0,1, 1,0,1,9, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0, 29, 8,0, 1,1,1,8, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0,  3, 8,0, 1,0,1,4, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0, 29, 8,0, 1,1,1,8, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0,  1, 2,1, 1,0,1,3, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0, 29, 8,0, 1,1,1,8, 0,0,0, NORM,1,0,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 1,0,0, FRZ, 1,0,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 1,0,0, FRZ, 1,1,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 1,0,0, FRZ, 1,2,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 1,1,0, LU,  1,3,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,0, NORM,2,3,0));
        vt.push_back(mk(0, 29, 8,0, 1,1,1,8, 0,0,0, NORM,2,3,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,1, BR,  2,3,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,0, NORM,2,3,0));
        vt.push_back(mk(0,  0, 0,0, 0,0,0,0, 1,0,1, FRZ, 2,3,0));
        vt.push_back(mk(0,  0, 0,0, 0,0,0,0, 0,0,0, NORM,2,4,0));
        vt.push_back(mk(0, 29, 8,0, 1,1,1,8, 0,0,0, NORM,2,4,0));
        vt.push_back(mk(1,  8,10,1, 1,0,1,9, 0,0,0, RST, 2,4,0));
        vt.push_back(mk(0,  8,10,1, 1,0,1,9, 0,0,0, NORM,0,0,0));

        foreach (vt[i]) begin
            drive(vt[i]);
            #3;
            chk($sformatf("row%0d_en", i), 32'(en), 32'(vt[i].en));
            chk($sformatf("row%0d_stall", i), 32'(stall_count), vt[i].sc);
            chk($sformatf("row%0d_freeze", i), 32'(freeze_count), vt[i].fc);
            chk($sformatf("row%0d_tmo", i), 32'(mem_timeout), 32'(vt[i].to));
            step();
        end

        for (int k = 1; k <= 6; k++) begin
            drive(mk(0, 0,0,0, 0,0,0,0, 1,0,0, FRZ,0,0,0));
            #3;
            chk($sformatf("tmo_frz%0d_en", k), 32'(en), 32'(FRZ));
            step();
            chk($sformatf("tmo_frz%0d_flag", k), 32'(mem_timeout),
                (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("tmo_frz%0d_fc", k), 32'(freeze_count), k);
        end
        for (int k = 0; k < 3; k++) begin
            drive(mk(0, 0,0,0, 0,0,0,0, 1,1,0, NORM,0,0,0));
            #3;
            chk($sformatf("tmo_rdy%0d_en", k), 32'(en), 32'(NORM));
            step();
            chk($sformatf("tmo_rdy%0d_flag", k), 32'(mem_timeout), 32'd1);
        end
        drive(mk(1, 0,0,0, 0,0,0,0, 1,0,0, RST,0,0,0));
        #3;
        chk("rst_frz_en", 32'(en), 32'(RST));
        step();
        drive(mk(0, 0,0,0, 0,0,0,0, 0,0,0, NORM,0,0,0));
        #3;
        chk("post_rst_en", 32'(en), 32'(NORM));
        chk("post_rst_tmo", 32'(mem_timeout), 32'd0);
        chk("post_rst_fc", 32'(freeze_count), 32'd0);
        step();

        for (int k = 0; k < 20; k++) begin
            drive(mk(0, 0,0,0, 0,0,0,0, 1,0,0, FRZ,0,0,0));
            step();
        end
        chk("fc_sat", 32'(freeze_count), 32'd15);
        chk("tmo_again", 32'(mem_timeout), 32'd1);

        for (int k = 0; k < 17; k++) begin
            drive(mk(0, 29,8,0, 1,1,1,8, 0,0,0, NORM,0,0,0));
            step();
            drive(mk(0, 8,10,1, 1,0,1,9, 0,0,0, LU,0,0,0));
            #3;
            chk($sformatf("sat_lu%0d_en", k), 32'(en), 32'(LU));
            step();
        end
        chk("sc_sat", 32'(stall_count), 32'd15);
        chk("fc_hold", 32'(freeze_count), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
